// File: rtl/pes_adder_pkg.sv
`default_nettype none
// ============================================================================
// pes_adder_pkg : shared types and constants for the serial half-adder sequencer
// Rev 1.0
// ============================================================================
package pes_adder_pkg;

   localparam int c_default_width = 8;
   localparam int c_latency       = 2 * c_default_width + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pes_half_adder.sv
`default_nettype none
// ============================================================================
// pes_half_adder : single-bit half adder shared by the serial sequencer
// Rev 1.0
// ============================================================================
module pes_half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_sum,
   output logic o_carry
);

   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;

endmodule
`default_nettype wire

// File: rtl/pes_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// pes_serial_add_ctrl : WIDTH-bit adder built from one half adder, two passes/bit
// Rev 1.0
// ============================================================================
module pes_serial_add_ctrl
   import pes_adder_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   input  logic             i_cin,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);

   localparam int               IDX_W      = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_sum;
   logic [IDX_W-1:0] r_idx;
   logic             r_s1;
   logic             r_c1;
   logic             r_carry;
   logic             r_carry_out;

   logic             w_ha_a;
   logic             w_ha_b;
   logic             w_ha_sum;
   logic             w_ha_carry;
   logic [WIDTH-1:0] w_next_result;
   logic             w_next_carry;
   logic             w_last_bit;

   pes_half_adder u_half_adder (
      .i_a     (w_ha_a),
      .i_b     (w_ha_b),
      .o_sum   (w_ha_sum),
      .o_carry (w_ha_carry)
   );

   // Input mux: operand bits in PASS1, partial sum and running carry in PASS2
   always_comb begin
      w_ha_a = 1'b0;
      w_ha_b = 1'b0;
      case (r_state)
         ST_PASS1: begin
            w_ha_a = r_op_a[r_idx];
            w_ha_b = r_op_b[r_idx];
         end
         ST_PASS2: begin
            w_ha_a = r_s1;
            w_ha_b = r_carry;
         end
         default: ;
      endcase
   end

   assign w_last_bit    = (r_idx == c_last_idx);
   assign w_next_result = {w_ha_sum, r_result[WIDTH-1:1]};
   // c1 and the second-pass carry are mutually exclusive, so OR is exact
   assign w_next_carry  = r_c1 | w_ha_carry;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (i_start) w_next_state = ST_PASS1;
         ST_PASS1: w_next_state = ST_PASS2;
         ST_PASS2: w_next_state = w_last_bit ? ST_DONE : ST_PASS1;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_result    <= '0;
         r_sum       <= '0;
         r_idx       <= '0;
         r_s1        <= 1'b0;
         r_c1        <= 1'b0;
         r_carry     <= 1'b0;
         r_carry_out <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_op_a  <= i_op_a;
                  r_op_b  <= i_op_b;
                  r_carry <= i_cin;
                  r_idx   <= '0;
               end
            end
            ST_PASS1: begin
               r_s1 <= w_ha_sum;
               r_c1 <= w_ha_carry;
            end
            ST_PASS2: begin
               r_result <= w_next_result;
               r_carry  <= w_next_carry;
               if (w_last_bit) begin
                  // Publish on the PASS2->DONE edge so outputs are valid during DONE
                  r_sum       <= w_next_result;
                  r_carry_out <= w_next_carry;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready = (r_state == ST_IDLE);
   assign o_busy  = (r_state == ST_PASS1) || (r_state == ST_PASS2);
   assign o_done  = (r_state == ST_DONE);
   assign o_sum   = r_sum;
   assign o_carry = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_pes_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pes_serial_add_ctrl : directed and randomised checks of the serial adder
// Rev 1.0
// ============================================================================
module tb_pes_serial_add_ctrl;
   import pes_adder_pkg::*;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   pes_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_op_a  (op_a),
      .i_op_b  (op_b),
      .i_cin   (cin),
      .o_ready (ready),
      .o_busy  (busy),
      .o_done  (done),
      .o_sum   (sum),
      .o_carry (carry)
   );

   always #5 clk = ~clk;

   // Exactly one of ready/busy/done must be high in every non-reset cycle
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         checks++;
         if (!$onehot({ready, busy, done})) begin
            failures++;
            $display("FAIL status_onehot got ready=%0b busy=%0b done=%0b exp one-hot", ready, busy, done);
         end
      end
   end

   // Called at a negedge in IDLE; returns cycles from acceptance to done, ends in IDLE
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         output int lat, output logic [7:0] s, output logic c);
      op_a  = a;
      op_b  = b;
      cin   = ci;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      s = sum;
      c = carry;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      cin   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
      checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%0b exp=0", carry); end
      // reset and start together: reset must win
      start = 1'b1;
      op_a  = 8'h12;
      op_b  = 8'h34;
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_start_same got ready=%0b busy=%0b exp ready=1 busy=0", ready, busy); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_start_dropped got ready=%0b exp=1", ready); end
      mon_en = 1'b1;
   endtask

   task automatic test_wrap();
      int lat; logic [7:0] s; logic c;
      run_op(8'hFF, 8'h01, 1'b0, lat, s, c);
      checks++; if (lat !== c_latency) begin failures++; $display("FAIL wrap_latency got=%0d exp=%0d", lat, c_latency); end
      checks++; if (s !== 8'h00) begin failures++; $display("FAIL wrap_sum got=%h exp=00", s); end
      checks++; if (c !== 1'b1) begin failures++; $display("FAIL wrap_carry got=%0b exp=1", c); end
   endtask

   task automatic test_cin();
      int lat; logic [7:0] s; logic c;
      run_op(8'hA5, 8'h5A, 1'b1, lat, s, c);
      checks++; if (s !== 8'h00 || c !== 1'b1) begin failures++; $display("FAIL cin1_result got=%0b_%h exp=1_00", c, s); end
      run_op(8'hA5, 8'h5A, 1'b0, lat, s, c);
      checks++; if (s !== 8'hFF || c !== 1'b0) begin failures++; $display("FAIL cin0_result got=%0b_%h exp=0_ff", c, s); end
      checks++; if (lat !== 17) begin failures++; $display("FAIL cin0_latency got=%0d exp=17", lat); end
   endtask

   task automatic test_start_while_busy();
      int n; int dones; logic [7:0] s; logic c;
      dones = 0; s = 8'hxx; c = 1'bx;
      op_a = 8'h03; op_b = 8'h04; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (n = 1; n <= 40; n++) begin
         if (done) begin dones++; s = sum; c = carry; end
         if (n == 5) begin op_a = 8'h11; op_b = 8'h22; start = 1'b1; end
         else start = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      checks++; if (dones !== 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", dones); end
      checks++; if (s !== 8'h07 || c !== 1'b0) begin failures++; $display("FAIL busy_start_result got=%0b_%h exp=0_07", c, s); end
      checks++; if (sum !== 8'h07) begin failures++; $display("FAIL busy_start_hold got=%h exp=07", sum); end
   endtask

   task automatic test_reset_mid();
      int dones; int lat; logic [7:0] s; logic c;
      dones = 0;
      op_a = 8'hF0; op_b = 8'h0F; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n < 9; n++) begin
         if (done) dones++;
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_state got ready=%0b busy=%0b exp ready=1 busy=0", ready, busy); end
      checks++; if (sum !== 8'h00 || carry !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs got=%0b_%h exp=0_00", carry, sum); end
      for (int n = 0; n < 20; n++) begin
         if (done) dones++;
         @(posedge clk);
         @(negedge clk);
      end
      checks++; if (dones !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", dones); end
      run_op(8'h01, 8'h01, 1'b0, lat, s, c);
      checks++; if (s !== 8'h02 || c !== 1'b0 || lat !== 17) begin failures++; $display("FAIL rst_mid_after got=%0b_%h lat=%0d exp=0_02 lat=17", c, s, lat); end
   endtask

   task automatic test_back_to_back();
      int t1; int t2; int dones; int hold_bad; bit rdy_after_done1;
      logic [7:0] s1; logic [7:0] s2; logic c1; logic c2;
      t1 = 0; t2 = 0; dones = 0; hold_bad = 0; rdy_after_done1 = 1'b0;
      s1 = 8'hxx; s2 = 8'hxx; c1 = 1'bx; c2 = 1'bx;
      op_a = 8'h10; op_b = 8'h20; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op_a = 8'h33; op_b = 8'h44; cin = 1'b1;
      for (int n = 1; n <= 60 && dones < 2; n++) begin
         if (done) begin
            dones++;
            if (dones == 1) begin t1 = n; s1 = sum; c1 = carry; end
            else begin t2 = n; s2 = sum; c2 = carry; start = 1'b0; end
         end else if (dones == 1) begin
            if (sum !== 8'h30) hold_bad++;
            if (n == t1 + 1 && ready) rdy_after_done1 = 1'b1;
         end
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (dones !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
      checks++; if (t1 !== 17) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=17", t1); end
      checks++; if (t2 - t1 !== 18) begin failures++; $display("FAIL b2b_spacing got=%0d exp=18", t2 - t1); end
      checks++; if (rdy_after_done1 !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_done got=%0b exp=1", rdy_after_done1); end
      checks++; if (s1 !== 8'h30 || c1 !== 1'b0) begin failures++; $display("FAIL b2b_first_result got=%0b_%h exp=0_30", c1, s1); end
      checks++; if (s2 !== 8'h78 || c2 !== 1'b0) begin failures++; $display("FAIL b2b_second_result got=%0b_%h exp=0_78", c2, s2); end
      checks++; if (hold_bad !== 0) begin failures++; $display("FAIL b2b_hold got=%0d bad cycles exp=0", hold_bad); end
      repeat (2) begin @(posedge clk); @(negedge clk); end
   endtask

   task automatic test_random();
      int lat; logic [7:0] s; logic c; logic [7:0] a; logic [7:0] b; logic ci;
      logic [8:0] exp_v;
      for (int i = 0; i < 1000; i++) begin
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 255));
         ci = 1'($urandom_range(0, 1));
         exp_v = {1'b0, a} + {1'b0, b} + {8'h00, ci};
         run_op(a, b, ci, lat, s, c);
         checks++;
         if (lat !== 17) begin failures++; $display("FAIL rand_latency op=%0d got=%0d exp=17", i, lat); end
         checks++;
         if ({c, s} !== exp_v) begin
            failures++;
            $display("FAIL rand_result op=%0d a=%h b=%h cin=%0b got=%h exp=%h", i, a, b, ci, {c, s}, exp_v);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
      @(negedge clk);
      test_reset();
      test_wrap();
      test_cin();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
